universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   Parametrised WIDTH-bit register built on the team's edge-triggered D flip-flop: every bit
//   is a master-slave DFF on clk, with synchronous reset, clock enable and an 8-mode
//   next-state selector (hold, shift, rotate, load, arithmetic shift, clear).
//   Serves as the generic storage/shift stage for serial links and test-scan chains.
// PARAMETERS
//   WIDTH      8      register width in bits, >= 2
//   RESET_VAL  0      WIDTH-bit value loaded into q on rst
// PORTS
//   clk      in   1      clock; all state changes on rising edge only
//   rst      in   1      synchronous reset, active-high
//   en       in   1      clock enable; 0 = hold regardless of mode
//   mode     in   3      operation select (see BEHAVIOUR)
//   d        in   WIDTH  parallel load data
//   sin_l    in   1      serial in, enters bit 0 on left shift
//   sin_r    in   1      serial in, enters bit WIDTH-1 on right shift
//   q        out  WIDTH  register contents
//   sout_l   out  1      = q[WIDTH-1] (bit shifted out on left shift)
//   sout_r   out  1      = q[0] (bit shifted out on right shift)
//   busy     out  1      1 in any cycle after an edge where q changed value, else 0
// BEHAVIOUR
//   - Reset: rst=1 at rising edge -> q=RESET_VAL, busy=0; rst dominates en and mode.
//     Reset asserted mid-operation discards the op of that cycle; no partial update.
//   - en=0 (rst=0): q and busy hold (busy forced 0 on next edge... no: busy <= 0).
//     Rule: busy <= (next_q != q) on every non-reset edge; with en=0, next_q=q so busy=0.
//   - Modes, applied at rising edge when en=1, rst=0 (latency 1 cycle, q updated same edge):
//     000 HOLD   q <= q
//     001 SHL    q <= {q[WIDTH-2:0], sin_l}
//     010 SHR    q <= {sin_r, q[WIDTH-1:1]}
//     011 ROL    q <= {q[WIDTH-2:0], q[WIDTH-1]}
//     100 ROR    q <= {q[0], q[WIDTH-1:1]}
//     101 LOAD   q <= d
//     110 ASR    q <= {q[WIDTH-1], q[WIDTH-1:1]}  (sign bit replicated)
//     111 CLR    q <= 0 (zero, not RESET_VAL)
//   - sout_l/sout_r are combinational from q: value shifted out at edge N is observable
//     on sout_* during cycle before edge N; no extra pipeline stage.
//   - Wrap-around: ROL/ROR of WIDTH consecutive cycles returns q to its start value.
//   - X/unknown mode values: treated as HOLD; no state corruption.
//   - No internal FSM beyond q and busy; all inputs sampled only at rising clk edge,
//     inputs changing between edges have no effect (edge-triggered, not transparent).
// TESTING
//   1. WIDTH=8, RESET_VAL=8'hA5: rst=1 one edge -> q=8'hA5, busy=0, sout_l=1, sout_r=1.
//   2. LOAD d=8'h3C, then SHL sin_l=1 x3 -> q=8'h3C, 8'h79, 8'hF3, 8'hE7; sout_l before
//      each shift = 0,0,1.
//   3. LOAD 8'h81, ROL x8 -> q returns to 8'h81 after edge 8; ROR x1 from 8'h81 -> 8'hC0.
//   4. LOAD 8'h90, ASR x2 -> 8'hC8, 8'hE4; LOAD 8'h10, ASR -> 8'h08.
//   5. en=0 with mode=SHL for 4 edges -> q unchanged, busy=0; CLR with en=1 -> q=0, busy=1
//      (if q was nonzero), next HOLD -> busy=0.
//   6. Mid-sequence rst during SHR with mode held -> q=RESET_VAL that edge, shifting resumes
//      from RESET_VAL on next edge after rst deasserts.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH-bit storage stage with synchronous reset, clock enable
// and an 8-way next-state selector (hold, shift, rotate, load, arithmetic shift, clear).
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous reset, active-high; loads RESET_VAL and clears busy
//   en     - clock enable; 0 holds q regardless of mode
//   mode   - operation select: HOLD, SHL, SHR, ROL, ROR, LOAD, ASR, CLR
//   d      - parallel load data
//   sin_l  - serial input entering bit 0 on a left shift
//   sin_r  - serial input entering bit WIDTH-1 on a right shift
//   q      - register contents
//   sout_l - q[WIDTH-1], the bit leaving on a left shift
//   sout_r - q[0], the bit leaving on a right shift
//   busy   - 1 in the cycle after any edge at which q changed value
module universal_shift_register #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeShl  = 3'b001,
    ModeShr  = 3'b010,
    ModeRol  = 3'b011,
    ModeRor  = 3'b100,
    ModeLoad = 3'b101,
    ModeAsr  = 3'b110,
    ModeClr  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_d, q_q;
  logic             busy_d, busy_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      // Unknown or unlisted encodings fall through to the default and hold.
      case (mode)
        ModeShl:  q_d = {q_q[WIDTH-2:0], sin_l};
        ModeShr:  q_d = {sin_r, q_q[WIDTH-1:1]};
        ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        ModeLoad: q_d = d;
        ModeAsr:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        ModeClr:  q_d = '0;
        default:  q_d = q_q;
      endcase
    end
    busy_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
    end
  end

  assign q      = q_q;
  assign busy   = busy_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  universal_shift_register #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .q     (q),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = M_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    step();
    n_vec++;
    if (q !== 8'hA5) begin
      n_err++; $display("FAIL reset_q: got %h, want a5", q);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b, want 0", busy);
    end
    n_vec++;
    if (sout_l !== 1'b1) begin
      n_err++; $display("FAIL reset_sout_l: got %b, want 1", sout_l);
    end
    n_vec++;
    if (sout_r !== 1'b1) begin
      n_err++; $display("FAIL reset_sout_r: got %b, want 1", sout_r);
    end
  endtask

  task automatic test_shl();
    logic [WIDTH-1:0] exp_q [3] = '{8'h79, 8'hF3, 8'hE7};
    logic             exp_so[3] = '{1'b0, 1'b0, 1'b1};
    rst = 1'b0; en = 1'b1; mode = M_LOAD; d = 8'h3C;
    step();
    n_vec++;
    if (q !== 8'h3C) begin
      n_err++; $display("FAIL shl_load_q: got %h, want 3c", q);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL shl_load_busy: got %b, want 1", busy);
    end
    mode = M_SHL; sin_l = 1'b1; d = 8'h00;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (sout_l !== exp_so[i]) begin
        n_err++; $display("FAIL shl_sout_l[%0d]: got %b, want %b", i, sout_l, exp_so[i]);
      end
      step();
      n_vec++;
      if (q !== exp_q[i]) begin
        n_err++; $display("FAIL shl_q[%0d]: got %h, want %h", i, q, exp_q[i]);
      end
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL shl_busy: got %b, want 1", busy);
    end
  endtask

  task automatic test_rotate();
    logic [WIDTH-1:0] exp_q[8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    mode = M_LOAD; d = 8'h81;
    step();
    n_vec++;
    if (q !== 8'h81) begin
      n_err++; $display("FAIL rot_load_q: got %h, want 81", q);
    end
    mode = M_ROL;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (q !== exp_q[i]) begin
        n_err++; $display("FAIL rol_q[%0d]: got %h, want %h", i, q, exp_q[i]);
      end
    end
    mode = M_ROR;
    step();
    n_vec++;
    if (q !== 8'hC0) begin
      n_err++; $display("FAIL ror_q: got %h, want c0", q);
    end
  endtask

  task automatic test_asr();
    mode = M_LOAD; d = 8'h90;
    step();
    mode = M_ASR;
    step();
    n_vec++;
    if (q !== 8'hC8) begin
      n_err++; $display("FAIL asr_q0: got %h, want c8", q);
    end
    step();
    n_vec++;
    if (q !== 8'hE4) begin
      n_err++; $display("FAIL asr_q1: got %h, want e4", q);
    end
    mode = M_LOAD; d = 8'h10;
    step();
    mode = M_ASR;
    step();
    n_vec++;
    if (q !== 8'h08) begin
      n_err++; $display("FAIL asr_pos: got %h, want 08", q);
    end
  endtask

  task automatic test_enable_clear();
    en = 1'b0; mode = M_SHL; sin_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (q !== 8'h08) begin
        n_err++; $display("FAIL en0_q[%0d]: got %h, want 08", i, q);
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL en0_busy[%0d]: got %b, want 0", i, busy);
      end
    end
    en = 1'b1; mode = M_CLR;
    step();
    n_vec++;
    if (q !== 8'h00) begin
      n_err++; $display("FAIL clr_q: got %h, want 00", q);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL clr_busy: got %b, want 1", busy);
    end
    mode = M_HOLD;
    step();
    n_vec++;
    if (q !== 8'h00) begin
      n_err++; $display("FAIL hold_q: got %h, want 00", q);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL hold_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_shr();
    mode = M_LOAD; d = 8'h3C;
    step();
    mode = M_SHR; sin_r = 1'b0;
    step();
    n_vec++;
    if (q !== 8'h1E) begin
      n_err++; $display("FAIL shr_q0: got %h, want 1e", q);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (q !== 8'hA5) begin
      n_err++; $display("FAIL shr_rst_q: got %h, want a5", q);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL shr_rst_busy: got %b, want 0", busy);
    end
    rst = 1'b0;
    n_vec++;
    if (sout_r !== 1'b1) begin
      n_err++; $display("FAIL shr_sout_r0: got %b, want 1", sout_r);
    end
    step();
    n_vec++;
    if (q !== 8'h52) begin
      n_err++; $display("FAIL shr_q1: got %h, want 52", q);
    end
    n_vec++;
    if (sout_r !== 1'b0) begin
      n_err++; $display("FAIL shr_sout_r1: got %b, want 0", sout_r);
    end
    sin_r = 1'b1;
    step();
    n_vec++;
    if (q !== 8'hA9) begin
      n_err++; $display("FAIL shr_q2: got %h, want a9", q);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL shr_busy: got %b, want 1", busy);
    end
  endtask

  // Inputs toggled between edges must not leak into q.
  task automatic test_between_edges();
    mode = M_HOLD; d = 8'h00;
    step();
    #2 mode = M_LOAD; d = 8'h5A;
    #2 mode = M_HOLD;
    step();
    n_vec++;
    if (q !== 8'hA9) begin
      n_err++; $display("FAIL glitch_q: got %h, want a9", q);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL glitch_busy: got %b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_rotate();
    test_asr();
    test_enable_clear();
    test_reset_mid_shr();
    test_between_edges();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
